// File: rtl/ras_ckpt_stack.sv
// ras_ckpt_stack: circular return address stack for the IF stage with
// ticket-indexed checkpoints. Predicted calls push and predicted returns pop.
// A misprediction restores a saved snapshot, or flushes the stack if the
// snapshot slot was never saved. Pushing onto a full stack overwrites the
// oldest entry.
module ras_ckpt_stack #(
  parameter int PC_BITS     = 32,
  parameter int RAS_DEPTH   = 8,
  parameter int TICKET_BITS = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push_i,
  input  logic [PC_BITS-1:0]             push_pc_i,
  input  logic                           pop_i,
  output logic [PC_BITS-1:0]             top_pc_o,
  output logic                           top_valid_o,
  output logic [$clog2(RAS_DEPTH+1)-1:0] count_o,
  output logic                           overflow_o,
  output logic                           underflow_o,
  input  logic                           ckpt_save_i,
  input  logic [TICKET_BITS-1:0]         ckpt_tag_i,
  input  logic                           restore_i,
  input  logic [TICKET_BITS-1:0]         restore_tag_i,
  output logic                           restore_err_o,
  input  logic                           flush_i
);

  localparam int PTR_BITS = $clog2(RAS_DEPTH);
  localparam int CNT_BITS = $clog2(RAS_DEPTH + 1);
  localparam int NSLOTS   = 2 ** TICKET_BITS;

  localparam logic [CNT_BITS-1:0] CNT_FULL = CNT_BITS'(RAS_DEPTH);
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);
  localparam logic [PTR_BITS-1:0] PTR_ONE  = PTR_BITS'(1);

  // Live stack state
  logic [PC_BITS-1:0]  entries [RAS_DEPTH];
  logic [PTR_BITS-1:0] tos;
  logic [CNT_BITS-1:0] count;

  // Checkpoint slots: valid bits plus saved {tos, count, top value}
  logic [NSLOTS-1:0]   ck_valid;
  logic [PTR_BITS-1:0] ck_tos   [NSLOTS];
  logic [CNT_BITS-1:0] ck_count [NSLOTS];
  logic [PC_BITS-1:0]  ck_top   [NSLOTS];

  // Next-state values produced by the update logic
  logic [PTR_BITS-1:0] tos_nxt;
  logic [CNT_BITS-1:0] count_nxt;
  logic                ent_we;
  logic [PTR_BITS-1:0] ent_widx;
  logic [PC_BITS-1:0]  ent_wdata;
  logic                overflow_nxt;
  logic                underflow_nxt;
  logic                restore_err_nxt;
  logic                clear_slots;
  logic                save_en;
  logic [PC_BITS-1:0]  save_top;
  logic [NSLOTS-1:0]   ck_valid_nxt;
  logic                restore_hit;

  assign restore_hit = ck_valid[restore_tag_i];
  assign save_en     = ckpt_save_i && !flush_i;

  // Stack update: flush beats restore, and restore beats push/pop
  always_comb begin
    // NOTE: every signal gets a default before the priority chain; a path
    // that leaves one unassigned would infer a latch.
    tos_nxt         = tos;
    count_nxt       = count;
    ent_we          = 1'b0;
    ent_widx        = tos;
    ent_wdata       = push_pc_i;
    overflow_nxt    = 1'b0;
    underflow_nxt   = 1'b0;
    restore_err_nxt = 1'b0;
    clear_slots     = 1'b0;

    if (flush_i) begin
      tos_nxt     = '0;
      count_nxt   = '0;
      clear_slots = 1'b1;
    end else if (restore_i) begin
      if (restore_hit) begin
        // Only the top entry is saved; deeper entries come from the array.
        tos_nxt   = ck_tos[restore_tag_i];
        count_nxt = ck_count[restore_tag_i];
        ent_we    = 1'b1;
        ent_widx  = ck_tos[restore_tag_i];
        ent_wdata = ck_top[restore_tag_i];
      end else begin
        // An unsaved slot means the history is unknown; start clean.
        tos_nxt         = '0;
        count_nxt       = '0;
        clear_slots     = 1'b1;
        restore_err_nxt = 1'b1;
      end
    end else if (push_i && pop_i) begin
      if (count == '0) begin
        // Pop of nothing plus a push is simply a push.
        tos_nxt   = tos + PTR_ONE;
        count_nxt = CNT_ONE;
        ent_we    = 1'b1;
        ent_widx  = tos + PTR_ONE;
      end else begin
        // Return then call: replace the top in place.
        ent_we   = 1'b1;
        ent_widx = tos;
      end
    end else if (push_i) begin
      tos_nxt  = tos + PTR_ONE;
      ent_we   = 1'b1;
      ent_widx = tos + PTR_ONE;
      if (count == CNT_FULL) begin
        overflow_nxt = 1'b1;
      end else begin
        count_nxt = count + CNT_ONE;
      end
    end else if (pop_i) begin
      if (count == '0) begin
        underflow_nxt = 1'b1;
      end else begin
        tos_nxt   = tos - PTR_ONE;
        count_nxt = count - CNT_ONE;
      end
    end
  end

  // Snapshot content: post-update top, forwarding this cycle's entry write
  always_comb begin
    save_top = entries[tos_nxt];
    if (ent_we && (ent_widx == tos_nxt)) begin
      save_top = ent_wdata;
    end
  end

  // Slot valid bits: a clear happens before a save in the same cycle
  always_comb begin
    ck_valid_nxt = ck_valid;
    if (clear_slots) begin
      ck_valid_nxt = '0;
    end
    if (save_en) begin
      ck_valid_nxt[ckpt_tag_i] = 1'b1;
    end
  end

  // Control state and pulse registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge.
    if (rst) begin
      tos           <= '0;
      count         <= '0;
      ck_valid      <= '0;
      overflow_o    <= 1'b0;
      underflow_o   <= 1'b0;
      restore_err_o <= 1'b0;
    end else begin
      tos           <= tos_nxt;
      count         <= count_nxt;
      ck_valid      <= ck_valid_nxt;
      overflow_o    <= overflow_nxt;
      underflow_o   <= underflow_nxt;
      restore_err_o <= restore_err_nxt;
    end
  end

  // Return address storage
  always_ff @(posedge clk) begin
    // NOTE: data arrays are not reset; count and the slot valid bits say
    // which contents are meaningful, and top_pc_o is masked while empty.
    if (ent_we) begin
      entries[ent_widx] <= ent_wdata;
    end
  end

  // Checkpoint payloads, guarded by ck_valid
  always_ff @(posedge clk) begin
    if (save_en) begin
      ck_tos[ckpt_tag_i]   <= tos_nxt;
      ck_count[ckpt_tag_i] <= count_nxt;
      ck_top[ckpt_tag_i]   <= save_top;
    end
  end

  assign top_valid_o = (count != '0);
  assign top_pc_o    = top_valid_o ? entries[tos] : '0;
  assign count_o     = count;

endmodule

// File: doc/ras_ckpt_stack.md
Name: ras_ckpt_stack

Overview:
- Parametrised return address stack for the IF stage; successor to the fixed 8-entry RAS.
- Circular storage with configurable depth and overflow wrap; reports overflow and underflow.
- Adds ticket-indexed checkpoints, so mispredictions restore the stack instead of corrupting it.
- Sits beside the gshare/BTB predictors. Pushed on predicted calls, popped on predicted returns, repaired on restart/flush.

Parameters:
- PC_BITS, 32, width of a stored return address.
- RAS_DEPTH, 8, number of entries; power of two, >=2.
- TICKET_BITS, 3, checkpoint tag width; 2**TICKET_BITS checkpoint slots.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- push_i  in  1  push push_pc_i (return address of a predicted call).
- push_pc_i  in  PC_BITS  address to push.
- pop_i  in  1  pop top entry (predicted return).
- top_pc_o  out  PC_BITS  current top-of-stack address, combinational from state.
- top_valid_o  out  1  stack non-empty (count_o != 0).
- count_o  out  $clog2(RAS_DEPTH+1)  live entries, 0..RAS_DEPTH.
- overflow_o  out  1  one-cycle pulse: push dropped oldest entry.
- underflow_o  out  1  one-cycle pulse: pop on empty stack.
- ckpt_save_i  in  1  save snapshot into slot ckpt_tag_i.
- ckpt_tag_i  in  TICKET_BITS  slot to save.
- restore_i  in  1  restore snapshot from slot restore_tag_i.
- restore_tag_i  in  TICKET_BITS  slot to restore.
- restore_err_o  out  1  one-cycle pulse: restore of an unsaved slot.
- flush_i  in  1  empty the stack, invalidate all checkpoints.

Behaviour:
- State
  - entry array [RAS_DEPTH], tos pointer (log2 DEPTH bits, index of top), count.
  - Per checkpoint slot: {valid, tos, count, top entry value}.
- Reset (async, immediate)
  - tos=0, count=0, all checkpoint valid=0.
  - top_pc_o=0, top_valid_o=0, count_o=0, overflow_o=underflow_o=restore_err_o=0.
  - Entry array contents are don't-care; top_pc_o is forced to 0 while count==0.
- Priority per cycle: flush_i > restore_i > push/pop. Lower-priority requests in the same cycle are ignored, except ckpt_save_i, which is ignored only under flush_i.
- Push only
  - tos<=tos+1 (mod DEPTH), entry[tos+1]<=push_pc_i, count<=min(count+1,DEPTH).
  - Push at count==DEPTH overwrites the oldest entry (wrap) and pulses overflow_o next cycle.
- Pop only
  - count>0: tos<=tos-1 (mod DEPTH), count<=count-1.
  - count==0: state unchanged, underflow_o pulses.
- Push and pop together
  - entry[tos]<=push_pc_i; tos and count unchanged.
  - At count==0 this acts as a push: count<=1, underflow_o does not pulse.
- Latency
  - A push/pop is visible on top_pc_o/count_o the cycle after the edge.
  - Pulses are registered and high exactly one cycle after the triggering edge.
- ckpt_save_i
  - Stores the post-update state of the same cycle (after this cycle's push/pop), including the resulting top entry value, and sets valid.
  - Re-saving an occupied slot overwrites it.
- restore_i with slot valid
  - tos<=saved tos, count<=saved count, entry[saved tos]<=saved top value.
  - Slot stays valid.
- restore_i with slot invalid: acts as flush (tos=0, count=0, all slots invalid) and pulses restore_err_o.
- Save and restore in the same cycle
  - Restore applies first; the save captures the restored state.
  - If both tags are equal, the save wins for the slot contents.
- flush_i: tos=0, count=0, all checkpoint valid=0; no pulses.
- Pointer arithmetic wraps modulo RAS_DEPTH. Count saturates at RAS_DEPTH and at 0, never wraps.

Test Plan:
- Reset, then push 0x100, 0x200, 0x300 -> top_pc_o=0x300, count_o=3; pop -> top_pc_o=0x200, count_o=2, top_valid_o=1.
- DEPTH=8: push 9 addresses 0x10..0x90 -> overflow_o pulses once on the 9th; count_o=8; 8 pops return 0x90..0x20; 9th pop -> underflow_o=1, count_o=0.
- Push and pop in one cycle on stack [0x40] -> top_pc_o=0x44, count_o=1; same on empty stack -> count_o=1, no underflow_o.
- Stack [0xA0,0xB0], ckpt_save_i tag=5 with pop in same cycle; push 0xC0, push 0xD0; restore_i tag=5 -> count_o=1, top_pc_o=0xA0.
- Save tag 2, flush_i, restore tag 2 -> restore_err_o=1 for one cycle, count_o=0; restore of never-saved tag 7 after reset -> restore_err_o=1.
- rst asserted mid-sequence with count_o=5 -> outputs 0 immediately, without waiting for a clock edge; prior checkpoints invalid (restore gives restore_err_o).
